// File: rtl/alt_vipitc120_common_timing_measure.sv
// Measures incoming video timing: samples per line, lines per frame, field cadence,
// and reports a stable flag once the measured totals repeat for several frames.
module alt_vipitc120_common_timing_measure #(
  parameter int TOTALS_MINUS_ONE = 0,
  parameter int STABLE_FRAMES    = 3,
  parameter int SYNC_POLARITY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        vid_hsync,
  input  logic        vid_vsync,
  input  logic        vid_field,
  output logic [13:0] total_sample_count,
  output logic        total_sample_count_valid,
  output logic [12:0] total_line_count,
  output logic        total_line_count_valid,
  output logic        start_of_vsync,
  output logic        field_prediction,
  output logic        interlaced,
  output logic        stable,
  output logic        clear_enable
);

  localparam logic       POL_INV = (SYNC_POLARITY == 0);
  localparam logic       M1      = (TOTALS_MINUS_ONE != 0);
  localparam logic [3:0] SF      = 4'(STABLE_FRAMES);

  logic        hs_act, vs_act;
  logic        hs_q, vs_q, fld_q, hs_prev, vs_prev;
  logic [13:0] h_cnt, h_cap;
  logic [12:0] v_cnt, v_sum, v_cap;
  logic        h_have, v_have, f_have, f_last;
  logic [3:0]  fc;
  logic        stable_q;
  logic        hedge, vedge, h_sat, v_sat;
  logic        s_vld_nxt, l_vld_nxt, ilace_nxt;

  assign hs_act = vid_hsync ^ POL_INV;
  assign vs_act = vid_vsync ^ POL_INV;

  always_comb begin
    hedge     = sample_tick & hs_q & ~hs_prev;
    vedge     = sample_tick & vs_q & ~vs_prev;
    h_sat     = &h_cnt;
    v_sat     = &v_cnt;
    h_cap     = M1 ? h_cnt : h_cnt + 14'd1;
    // a line edge on the same tick as the frame edge belongs to the ending frame
    v_sum     = v_cnt + {12'd0, hedge};
    v_cap     = M1 ? v_sum - 13'd1 : v_sum;
    s_vld_nxt = total_sample_count_valid;
    l_vld_nxt = total_line_count_valid;
    if (hedge) s_vld_nxt = !h_sat && h_have && (h_cap == total_sample_count);
    if (vedge) l_vld_nxt = !v_sat && v_have && (v_cap == total_line_count);
    ilace_nxt = f_have & (fld_q ^ f_last);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // edge detector reloads from the live level so an already-active sync is not an edge
      hs_q                     <= hs_act;
      vs_q                     <= vs_act;
      hs_prev                  <= hs_act;
      vs_prev                  <= vs_act;
      fld_q                    <= 1'b0;
      h_cnt                    <= '0;
      v_cnt                    <= '0;
      h_have                   <= 1'b0;
      v_have                   <= 1'b0;
      f_have                   <= 1'b0;
      f_last                   <= 1'b0;
      fc                       <= '0;
      stable_q                 <= 1'b0;
      total_sample_count       <= '0;
      total_sample_count_valid <= 1'b0;
      total_line_count         <= '0;
      total_line_count_valid   <= 1'b0;
      start_of_vsync           <= 1'b0;
      field_prediction         <= 1'b0;
      interlaced               <= 1'b0;
    end else begin
      hs_q           <= hs_act;
      vs_q           <= vs_act;
      fld_q          <= vid_field;
      stable_q       <= stable;
      start_of_vsync <= vedge;
      if (sample_tick) begin
        hs_prev <= hs_q;
        vs_prev <= vs_q;

        if (hedge)       h_cnt <= '0;
        else if (!h_sat) h_cnt <= h_cnt + 14'd1;
        if (hedge) begin
          total_sample_count_valid <= s_vld_nxt;
          h_have                   <= !h_sat;
          if (!h_sat) total_sample_count <= h_cap;
        end

        if (vedge)                v_cnt <= '0;
        else if (hedge && !v_sat) v_cnt <= v_cnt + 13'd1;
        if (vedge) begin
          total_line_count_valid <= l_vld_nxt;
          v_have                 <= !v_sat;
          if (!v_sat) total_line_count <= v_cap;
        end

        // any loss of validity restarts the frame qualification count
        if (!(s_vld_nxt && l_vld_nxt)) fc <= '0;
        else if (vedge && fc != SF)     fc <= fc + 4'd1;

        if (vedge) begin
          f_last           <= fld_q;
          f_have           <= 1'b1;
          interlaced       <= ilace_nxt;
          field_prediction <= ilace_nxt & ~fld_q;
        end
      end
    end
  end

  assign stable       = (fc == SF) && total_sample_count_valid && total_line_count_valid;
  assign clear_enable = stable_q & ~stable;

endmodule

// File: tb/tb_alt_vipitc120_common_timing_measure.sv
// Directed bench: scaled-down video timing (20 samples x 8 lines) driven into two
// instances, one with default parameters and one with minus-one totals and low syncs.
module tb_alt_vipitc120_common_timing_measure;
  localparam int HP = 20;
  localparam int LN = 8;

  logic clk = 1'b0, rst = 1'b0, sample_tick = 1'b0, hs = 1'b0, vs = 1'b0, fld = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] s0_cnt, s1_cnt;
  logic [12:0] l0_cnt, l1_cnt;
  logic s0_v, l0_v, sov0, fp0, il0, st0, ce0;
  logic s1_v, l1_v, sov1, fp1, il1, st1, ce1;

  alt_vipitc120_common_timing_measure dut0 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .vid_hsync(hs), .vid_vsync(vs), .vid_field(fld),
    .total_sample_count(s0_cnt), .total_sample_count_valid(s0_v),
    .total_line_count(l0_cnt), .total_line_count_valid(l0_v),
    .start_of_vsync(sov0), .field_prediction(fp0), .interlaced(il0),
    .stable(st0), .clear_enable(ce0));

  alt_vipitc120_common_timing_measure #(.TOTALS_MINUS_ONE(1), .SYNC_POLARITY(0)) dut1 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .vid_hsync(~hs), .vid_vsync(~vs), .vid_field(fld),
    .total_sample_count(s1_cnt), .total_sample_count_valid(s1_v),
    .total_line_count(l1_cnt), .total_line_count_valid(l1_v),
    .start_of_vsync(sov1), .field_prediction(fp1), .interlaced(il1),
    .stable(st1), .clear_enable(ce1));

  int n_chk = 0, n_fail = 0;
  int sov_n = 0, ce_n = 0;
  int base;

  always @(negedge clk) begin
    if (sov0) sov_n++;
    if (ce0)  ce_n++;
  end

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(bit h, bit v, int div);
    @(negedge clk);
    sample_tick = 1'b1; hs = h; vs = v;
    repeat (div - 1) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  task automatic line(int len, bit vsl, int div);
    for (int s = 0; s < len; s++) tick(s < 2, vsl, div);
  endtask

  task automatic frame(bit f, int div);
    fld = f;
    for (int l = 0; l < LN; l++) line(HP, l < 2, div);
  endtask

  task automatic rst_checks(string tag);
    check({tag, "_scnt"}, int'(s0_cnt), 0);
    check({tag, "_lcnt"}, int'(l0_cnt), 0);
    check({tag, "_flags"}, int'({s0_v, l0_v, sov0, fp0, il0, st0, ce0}), 0);
    check({tag, "_dut1"}, int'({s1_cnt, l1_cnt, s1_v, l1_v, st1, ce1}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_checks("init");
    rst = 1'b1;

    // progressive: 4 frames -> totals valid but only two qualifying frames so far
    repeat (4) frame(1'b0, 1);
    idle(3);
    check("scnt", int'(s0_cnt), 20);
    check("lcnt", int'(l0_cnt), 8);
    check("valids", int'({s0_v, l0_v}), 3);
    check("stable_early", int'(st0), 0);
    frame(1'b0, 1);
    idle(3);
    check("stable", int'(st0), 1);
    check("interlaced_prog", int'(il0), 0);
    check("m1_scnt", int'(s1_cnt), 19);
    check("m1_lcnt", int'(l1_cnt), 7);
    check("m1_stable", int'(st1), 1);

    // one 21-sample line inside an otherwise good frame
    base = ce_n;
    fld = 1'b0;
    for (int l = 0; l < 3; l++) line(HP, l < 2, 1);
    line(HP + 1, 1'b0, 1);
    idle(3);
    check("stable_before_cap", int'(st0), 1);
    line(HP, 1'b0, 1);
    idle(3);
    check("bad_scnt", int'(s0_cnt), 21);
    check("bad_valid", int'(s0_v), 0);
    check("bad_stable", int'(st0), 0);
    check("clear_pulse", ce_n - base, 1);
    for (int l = 5; l < LN; l++) line(HP, 1'b0, 1);
    idle(3);
    check("recover_valid", int'(s0_v), 1);
    check("recover_not_stable", int'(st0), 0);
    repeat (2) frame(1'b0, 1);
    idle(3);
    check("recover_2frames", int'(st0), 0);
    frame(1'b0, 1);
    idle(3);
    check("recover_3frames", int'(st0), 1);

    // alternating field
    base = sov_n;
    frame(1'b1, 1); idle(3);
    check("il_a", int'(il0), 1);
    check("fp_a", int'(fp0), 0);
    frame(1'b0, 1); idle(3);
    check("fp_b", int'(fp0), 1);
    frame(1'b1, 1); idle(3);
    check("fp_c", int'(fp0), 0);
    check("sov_width", sov_n - base, 3);

    // reset, then 1-in-2 sample ticks
    @(negedge clk); rst = 1'b0; fld = 1'b0;
    @(negedge clk);
    rst_checks("rst2");
    rst = 1'b1;
    repeat (5) frame(1'b0, 2);
    idle(3);
    check("div2_scnt", int'(s0_cnt), 20);
    check("div2_lcnt", int'(l0_cnt), 8);
    check("div2_stable", int'(st0), 1);
    check("div2_il", int'(il0), 0);
    check("div2_m1", int'({s1_cnt, l1_cnt}), int'({14'd19, 13'd7}));

    // hsync absent long enough to saturate the sample counter
    base = ce_n;
    repeat (20000) tick(1'b0, 1'b0, 1);
    line(HP, 1'b0, 1);
    idle(3);
    check("ovf_valid", int'(s0_v), 0);
    check("ovf_stable", int'(st0), 0);
    check("ovf_scnt_held", int'(s0_cnt), 20);
    check("ovf_m1_held", int'(s1_cnt), 19);
    check("ovf_clear", ce_n - base, 1);

    // mid-frame reset while hsync is active
    repeat (3) line(HP, 1'b0, 1);
    @(negedge clk); rst = 1'b0; hs = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    rst_checks("mid");
    rst = 1'b1;
    repeat (5) tick(1'b1, 1'b0, 1);
    repeat (10) tick(1'b0, 1'b0, 1);
    idle(3);
    check("no_edge_at_release", int'(s0_cnt), 0);
    line(HP, 1'b0, 1); idle(3);
    check("first_cap_invalid", int'(s0_v), 0);
    line(HP, 1'b0, 1); idle(3);
    check("second_cap_cnt", int'(s0_cnt), 20);
    check("second_cap_invalid", int'(s0_v), 0);
    line(HP, 1'b0, 1); idle(3);
    check("third_cap_valid", int'(s0_v), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alt_vipitc120_common_timing_measure.md
ALT_VIPITC120_COMMON_TIMING_MEASURE -- requirements
Module: alt_vipitc120_common_timing_measure

Interface
REQ-001 SHALL have parameter TOTALS_MINUS_ONE, default 0, meaning: 1 = reported totals are period-1, 0 = period.
REQ-002 SHALL have parameter STABLE_FRAMES, default 3, range 1-15, meaning: consecutive matching frames before stable asserts.
REQ-003 SHALL have parameter SYNC_POLARITY, default 1, meaning: 1 = syncs active-high, 0 = active-low.
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: sample_tick  in  1  qualifies one video sample this cycle.
REQ-007 SHALL have ports: vid_hsync  in  1; vid_vsync  in  1; vid_field  in  1  field bit of incoming video.
REQ-008 SHALL have ports: total_sample_count  out  14; total_sample_count_valid  out  1.
REQ-009 SHALL have ports: total_line_count  out  13; total_line_count_valid  out  1.
REQ-010 SHALL have ports: start_of_vsync  out  1; field_prediction  out  1; interlaced  out  1; stable  out  1; clear_enable  out  1.

Function
REQ-011 SHALL register hsync/vsync (XORed with ~SYNC_POLARITY) once; active edge = inactive->active transition of the registered value, evaluated only on sample_tick cycles.
REQ-012 SHALL count sample_ticks in 14-bit h_cnt; on hsync edge, capture h_cnt+1 (period, TOTALS_MINUS_ONE=0) or h_cnt (TOTALS_MINUS_ONE=1), then restart h_cnt at 0 on that same tick.
REQ-013 SHALL saturate h_cnt at 16383; a capture taken while saturated SHALL clear total_sample_count_valid and SHALL not update total_sample_count.
REQ-014 SHALL assert total_sample_count_valid the cycle after a capture equal to the previous capture; SHALL deassert it the cycle after any unequal capture; total_sample_count updates on every non-overflow capture.
REQ-015 SHALL count hsync edges in 13-bit v_cnt, saturating at 8191; on vsync edge, capture and validate exactly as REQ-012..014 into total_line_count/total_line_count_valid.
REQ-016 Hsync and vsync edges on the same tick: v_cnt SHALL capture including that hsync edge, then restart at 0.
REQ-017 SHALL pulse start_of_vsync high for exactly one clk, one cycle after the vsync edge tick.
REQ-018 SHALL sample vid_field at each vsync edge; interlaced SHALL be 1 when the last two samples differ, 0 when equal; field_prediction SHALL be ~last_sample when interlaced, else 0; both update with start_of_vsync.
REQ-019 SHALL keep 4-bit frame counter fc: on each vsync edge, if both valids are 1 (after that edge's update), fc increments saturating at STABLE_FRAMES, else fc=0.
REQ-020 stable SHALL be 1 when fc==STABLE_FRAMES and both valids are 1; SHALL drop the cycle either valid drops, without waiting for vsync.
REQ-021 clear_enable SHALL pulse one clk on each 1->0 transition of stable.
REQ-022 SHALL hold all counters and outputs (except pulse clears) when sample_tick=0; start_of_vsync and clear_enable SHALL return to 0 regardless of sample_tick.

Reset
REQ-023 rst=0 at a clock edge SHALL clear all counters, captures, fc and edge registers, and drive every output to 0 the following cycle.
REQ-024 Reset mid-frame SHALL discard partial counts; first post-reset capture SHALL never assert a valid (no previous capture).
REQ-025 Edge detector SHALL reload from current sync level on reset release, so a sync already active at release is not an edge.

Verification
REQ-026 Progressive 800x525 (hsync every 800 ticks, vsync every 525 lines), TOTALS_MINUS_ONE=0, STABLE_FRAMES=3 -> total_sample_count=800, total_line_count=525, stable=1 after 3rd full matching frame, interlaced=0.
REQ-027 Same timing with TOTALS_MINUS_ONE=1 -> totals 799 and 524.
REQ-028 Stable stream, then one line of 801 samples -> total_sample_count_valid and stable drop next cycle, clear_enable single pulse, stable returns after 3 further good frames.
REQ-029 Field alternating 0/1 at each vsync -> interlaced=1, field_prediction toggles opposite the last sampled field, start_of_vsync one clk wide.
REQ-030 Hsync absent for 20000 ticks -> capture suppressed, valid=0, stable=0; rst=0 mid-frame -> all outputs 0 next cycle.
REQ-031 sample_tick toggling 1-in-2 with 1600-clk line -> total_sample_count=800, identical results to REQ-026.
